// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard FSM state encoding, stall counter width and the
// bundle of pipeline control outputs produced by the hazard unit.
package cpu_types_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } hazard_ctrl_t;

    // Control patterns, field order {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl}.
    // idex_en stays high in CTRL_LU and ifid_en in CTRL_MISS: the flush wins anyway.
    localparam hazard_ctrl_t CTRL_RUN    = hazard_ctrl_t'(7'b1111100);
    localparam hazard_ctrl_t CTRL_FREEZE = hazard_ctrl_t'(7'b0000000);
    localparam hazard_ctrl_t CTRL_FLUSH  = hazard_ctrl_t'(7'b1111111);
    localparam hazard_ctrl_t CTRL_LU     = hazard_ctrl_t'(7'b0011101);
    localparam hazard_ctrl_t CTRL_MISS   = hazard_ctrl_t'(7'b0111110);

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline status inputs and stall/flush control outputs of the hazard unit.
// The pipeline (or a bench) is the master; the hazard unit is the slave.
interface hazard_unit_if;

    logic        ihit;
    logic        dhit;
    logic [31:0] ifid_imemload;
    logic        idex_dREN;
    logic [4:0]  idex_wsel;
    logic        exmem_dREN;
    logic        exmem_dWEN;
    logic        branch_taken;
    logic        halt;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic [cpu_types_pkg::STALL_CNT_W-1:0] stall_count;
    logic [1:0]  state_o;

    modport master (
        output ihit, dhit, ifid_imemload, idex_dREN, idex_wsel,
               exmem_dREN, exmem_dWEN, branch_taken, halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, stall_count, state_o
    );

    modport slave (
        input  ihit, dhit, ifid_imemload, idex_dREN, idex_wsel,
               exmem_dREN, exmem_dWEN, branch_taken, halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, stall_count, state_o
    );

endinterface

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: a load in EX whose destination is a source of the
// instruction in decode. Register 0 never matches.
module hazard_lu_detect (
    input  logic        dren,
    input  logic [4:0]  wsel,
    input  logic [31:0] instr,
    output logic        lu_hit
);

    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_bits;

    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign unused_bits = ^{instr[31:26], instr[15:0]};

    assign lu_hit = dren & (wsel != 5'd0) & ((wsel == rs) | (wsel == rt));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory freeze, branch flush, load-use stall, fetch
// miss bubble and halt, plus a saturating stall/flush cycle counter.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    hazard_unit_if.slave hif
);

    hazard_state_t              state;
    hazard_state_t              state_nxt;
    hazard_ctrl_t               ctrl;
    logic                       lu_raw;
    logic                       lu_hit;
    logic                       mem_busy;
    logic                       stall;
    logic [STALL_CNT_W-1:0]     cnt;

    hazard_lu_detect u_lu (
        .dren   (hif.idex_dREN),
        .wsel   (hif.idex_wsel),
        .instr  (hif.ifid_imemload),
        .lu_hit (lu_raw)
    );

    assign mem_busy = (hif.exmem_dREN | hif.exmem_dWEN) & ~hif.dhit;
    // In LU_STALL the EX stage already holds the bubble; ignore a stale match.
    assign lu_hit   = lu_raw & (state != LU_STALL);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = RUN;
        ctrl      = CTRL_RUN;
        if (state == HALTED || hif.halt) begin
            state_nxt = HALTED;
            ctrl      = CTRL_FREEZE;
        end else if (mem_busy) begin
            state_nxt = MEM_WAIT;
            ctrl      = CTRL_FREEZE;
        end else if (hif.branch_taken) begin
            ctrl      = CTRL_FLUSH;
        end else if (lu_hit) begin
            state_nxt = LU_STALL;
            ctrl      = CTRL_LU;
        end else if (!hif.ihit) begin
            ctrl      = CTRL_MISS;
        end
    end

    assign stall = (state != HALTED) & (~ctrl.pc_en | ctrl.ifid_flush | ctrl.idex_flush);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                 cnt <= '0;
        else if (stall && cnt != '1) cnt <= cnt + STALL_CNT_W'(1);
    end

    assign hif.pc_en       = ctrl.pc_en;
    assign hif.ifid_en     = ctrl.ifid_en;
    assign hif.idex_en     = ctrl.idex_en;
    assign hif.exmem_en    = ctrl.exmem_en;
    assign hif.memwb_en    = ctrl.memwb_en;
    assign hif.ifid_flush  = ctrl.ifid_flush;
    assign hif.idex_flush  = ctrl.idex_flush;
    assign hif.stall_count = cnt;
    assign hif.state_o     = state;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a priority-rule model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_hazard_unit;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    hazard_unit_if hif();

    hazard_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hif  (hif)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0 run, 1 waiting on memory, 2 just stalled for a load, 3 halted
    int cnt_m = 0;

    logic [6:0] dut_ctrl;
    logic [4:0] dut_en;
    assign dut_ctrl = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                       hif.ifid_flush, hif.idex_flush};
    assign dut_en   = dut_ctrl[6:2];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (hif.exmem_dREN || hif.exmem_dWEN) && !hif.dhit;
    endfunction

    function automatic bit m_lu();
        logic [31:0] ins;
        ins = hif.ifid_imemload;
        return hif.idex_dREN && hif.idex_wsel != 5'd0 &&
               (hif.idex_wsel == ins[25:21] || hif.idex_wsel == ins[20:16]);
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] model_ctrl(input int m);
        if (m == 3 || hif.halt)        return 7'b0000000;
        if (m_busy())                  return 7'b0000000;
        if (hif.branch_taken)          return 7'b1111111;
        if (m != 2 && m_lu())          return 7'b0011101;
        if (!hif.ihit)                 return 7'b0111110;
        return 7'b1111100;
    endfunction

    function automatic int model_next(input int m);
        if (m == 3 || hif.halt) return 3;
        if (m_busy())           return 1;
        if (hif.branch_taken)   return 0;
        if (m != 2 && m_lu())   return 2;
        return 0;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        logic [6:0] c;
        if (!nRST) begin
            mode  = 0;
            cnt_m = 0;
        end else begin
            c = model_ctrl(mode);
            if (mode != 3 && (!c[6] || c[1] || c[0]) && cnt_m < 65535) cnt_m++;
            mode = model_next(mode);
        end
    end

    always @(negedge CLK) begin
        check("model_ctrl",  dut_ctrl,        model_ctrl(mode));
        check("model_state", hif.state_o,     mode);
        check("model_count", hif.stall_count, cnt_m);
    end

    task automatic idle();
        hif.ihit          = 1'b1;
        hif.dhit          = 1'b0;
        hif.ifid_imemload = 32'd0;
        hif.idex_dREN     = 1'b0;
        hif.idex_wsel     = 5'd0;
        hif.exmem_dREN    = 1'b0;
        hif.exmem_dWEN    = 1'b0;
        hif.branch_taken  = 1'b0;
        hif.halt          = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        idle();
        #2;
        check("rst_state", hif.state_o, 0);
        check("rst_count", hif.stall_count, 0);
        tick();
        tick();
        nRST = 1'b1;

        // load-use on rs
        tick();
        hif.idex_dREN = 1'b1; hif.idex_wsel = 5'd5; hif.ifid_imemload = 32'd5 << 21;
        sample();
        check("lu_pc_en",     hif.pc_en,      0);
        check("lu_ifid_en",   hif.ifid_en,    0);
        check("lu_idex_fl",   hif.idex_flush, 1);
        check("lu_ifid_fl",   hif.ifid_flush, 0);
        tick();
        hif.idex_dREN = 1'b0;
        sample();
        check("lu2_enables",  dut_en,          5'h1F);
        check("lu2_state",    hif.state_o,     2);
        check("lu2_count",    hif.stall_count, 1);

        // register zero never stalls
        tick();
        hif.idex_dREN = 1'b1; hif.idex_wsel = 5'd0; hif.ifid_imemload = 32'd0;
        sample();
        check("r0_ctrl",  dut_ctrl, 7'b1111100);
        tick();
        idle();
        sample();
        check("r0_count", hif.stall_count, 1);
        check("r0_state", hif.state_o, 0);

        // load-use on rt
        tick();
        hif.idex_dREN = 1'b1; hif.idex_wsel = 5'd7; hif.ifid_imemload = 32'd7 << 16;
        sample();
        check("rt_ctrl", dut_ctrl, 7'b0011101);
        tick();
        idle();
        sample();
        check("rt_count", hif.stall_count, 2);

        // memory wait, three busy cycles then dhit
        tick();
        hif.exmem_dREN = 1'b1; hif.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("mw_enables", dut_en, 0);
            check("mw_flushes", dut_ctrl[1:0], 0);
            if (i > 0) check("mw_state", hif.state_o, 1);
            tick();
        end
        hif.dhit = 1'b1;
        sample();
        check("mw_rel_en",    dut_en, 5'h1F);
        check("mw_rel_state", hif.state_o, 1);
        tick();
        idle();
        sample();
        check("mw_state_run", hif.state_o, 0);
        check("mw_count",     hif.stall_count, 5);

        // branch wins over load-use
        tick();
        hif.branch_taken = 1'b1; hif.idex_dREN = 1'b1; hif.idex_wsel = 5'd3;
        hif.ifid_imemload = 32'd3 << 21;
        sample();
        check("br_ctrl", dut_ctrl, 7'b1111111);
        tick();
        idle();
        sample();
        check("br_state", hif.state_o, 0);
        check("br_count", hif.stall_count, 6);

        // fetch miss bubble
        tick();
        hif.ihit = 1'b0;
        sample();
        check("miss_ctrl", dut_ctrl, 7'b0111110);
        tick();
        idle();
        sample();
        check("miss_count", hif.stall_count, 7);

        // store that completes in the same cycle is not a freeze
        tick();
        hif.exmem_dWEN = 1'b1; hif.dhit = 1'b1;
        sample();
        check("st_hit_ctrl", dut_ctrl, 7'b1111100);

        // halt is sticky and freezes everything without counting
        tick();
        idle();
        hif.halt = 1'b1;
        sample();
        check("halt_en", dut_en, 0);
        tick();
        hif.halt = 1'b0; hif.ihit = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample();
            check("halted_state", hif.state_o, 3);
            check("halted_ctrl",  dut_ctrl, 0);
            tick();
        end
        check("halted_count", hif.stall_count, 8);

        // reset mid-cycle acts immediately
        #2;
        nRST = 1'b0;
        #1;
        check("arst_state", hif.state_o, 0);
        check("arst_count", hif.stall_count, 0);
        idle();
        tick();
        nRST = 1'b1;

        // a MEM_WAIT interrupted by reset leaves no residual stall
        tick();
        hif.exmem_dREN = 1'b1; hif.dhit = 1'b0;
        tick();
        tick();
        check("mw_pre_rst_state", hif.state_o, 1);
        #2;
        nRST = 1'b0;
        #1;
        check("mw_rst_state", hif.state_o, 0);
        idle();
        tick();
        nRST = 1'b1;
        sample();
        check("mw_post_rst_ctrl",  dut_ctrl, 7'b1111100);
        tick();
        sample();
        check("mw_post_rst_state", hif.state_o, 0);
        check("mw_post_rst_count", hif.stall_count, 0);

        // saturation
        tick();
        hif.ihit = 1'b0;
        repeat (70000) tick();
        sample();
        check("sat_count", hif.stall_count, 16'hFFFF);
        check("sat_pc_en", hif.pc_en, 0);
        tick();
        sample();
        check("sat_hold", hif.stall_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 Port nRST  in  1  reset, asynchronous, active-low.
REQ-003 Port ihit  in  1  instruction fetch complete this cycle.
REQ-004 Port dhit  in  1  data access in MEM complete this cycle.
REQ-005 Port ifid_imemload  in  32  instruction in decode; rs = bits 25:21, rt = bits 20:16.
REQ-006 Port idex_dREN  in  1  instruction in EX is a load.
REQ-007 Port idex_wsel  in  5  destination register of the instruction in EX.
REQ-008 Port exmem_dREN, exmem_dWEN  in  1 each  memory read/write pending in MEM.
REQ-009 Port branch_taken  in  1  redirect resolved in EX; covers taken branch, jump, jr.
REQ-010 Port halt  in  1  halt instruction has reached MEM/WB.
REQ-011 Port pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  PC and pipeline-register write enables.
REQ-012 Port ifid_flush, idex_flush  out  1 each  load bubble (all-zero control) into that register at the next edge.
REQ-013 Port stall_count  out  16  saturating count of stall or flush cycles.
REQ-014 Port state_o  out  2  current FSM state, for debug.

Function
REQ-015 FSM states: RUN=0, MEM_WAIT=1, LU_STALL=2, HALTED=3; state_o shall equal the state register.
REQ-016 Define mem_busy = (exmem_dREN|exmem_dWEN) & ~dhit.
REQ-017 Define lu_hit = idex_dREN & (idex_wsel!=0) & (idex_wsel==rs | idex_wsel==rt).
REQ-018 Outputs shall be combinational from the current state and inputs; conditions below are listed in priority order, highest first.
REQ-019 In HALTED, or whenever halt=1: all enables 0 and both flushes 0.
REQ-020 mem_busy: all five enables 0 and both flushes 0 (full freeze); the next state is MEM_WAIT.
REQ-021 branch_taken (no mem_busy): pc_en=1 and ifid_flush=idex_flush=1; the remaining enables are 1.
REQ-022 lu_hit (none of the above): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; the next state is LU_STALL.
REQ-023 ~ihit (none of the above): pc_en=0, ifid_flush=1, and all other enables 1.
REQ-024 Otherwise: all enables 1 and both flushes 0.
REQ-025 MEM_WAIT shall return to RUN on the first cycle mem_busy=0; that cycle shall apply the REQ-021..024 priorities.
REQ-026 LU_STALL shall last exactly one cycle, then return to RUN; it shall not re-stall for the same load because idex now holds a bubble.
REQ-027 halt=1 shall force the next state to HALTED from any state; HALTED is sticky until reset.
REQ-028 Flush and enable to the same register in the same cycle: flush shall win (bubble loaded).
REQ-029 stall_count shall increment by 1 on every cycle in which pc_en=0 or any flush=1, excluding HALTED; it shall saturate at 0xFFFF.
REQ-030 Register 0 shall never cause a load-use stall.

Reset
REQ-031 nRST=0 shall immediately force state=RUN and stall_count=0, regardless of CLK.
REQ-032 While nRST=0, outputs shall follow the RUN rules; an in-progress MEM_WAIT or LU_STALL shall be abandoned without a residual stall after release.

Structure
REQ-033 The state enum hazard_state_t and the width constant STALL_CNT_W=16 shall live in cpu_types_pkg.
REQ-034 The load-use comparator shall be a sub-module, hazard_lu_detect (combinational); the FSM and counter stay in hazard_unit.
REQ-035 No other sub-modules shall be used; the unit shall be a single clock domain.

Verification
REQ-036 Load-use: idex_dREN=1, idex_wsel=5, ifid rs=5, ihit=1 -> cycle 1: pc_en=0, ifid_en=0, idex_flush=1; cycle 2: all enables 1; stall_count=1.
REQ-037 Register zero: same as REQ-036 with idex_wsel=0, rs=0 -> no stall; stall_count unchanged.
REQ-038 Memory wait: exmem_dREN=1 with dhit low for 3 cycles -> all enables 0 for 3 cycles, state_o=1; the 4th cycle (dhit=1) restores enables 1; stall_count=3.
REQ-039 Branch versus load-use in the same cycle: branch_taken=1 and lu_hit=1 -> ifid_flush=idex_flush=1, pc_en=1, and no LU_STALL entered.
REQ-040 Halt and reset: halt pulse -> state_o=3 and all enables 0 for 10+ cycles; nRST low mid-cycle -> state_o=0 and stall_count=0 immediately.
REQ-041 Saturation: force 70000 ~ihit cycles -> stall_count holds at 0xFFFF.
